// File: rtl/systolic_feeder.sv
// Operand skew and control stage for an NxN FP8 systolic array.
// Feeds skewed A/B lanes, clear pulses per PE, and a done pulse when the tile has drained.
module systolic_feeder #(
  parameter int unsigned N  = 2,
  parameter int unsigned KW = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [KW-1:0]    i_k_len,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [8*N-1:0]   i_in_a,
  input  logic [8*N-1:0]   i_in_b,
  output logic [8*N-1:0]   o_a_edge,
  output logic [8*N-1:0]   o_b_edge,
  output logic [N*N-1:0]   o_clear_pe,
  output logic             o_busy,
  output logic             o_done
);

  typedef enum logic [1:0] {StIdle, StFeed, StDrain} state_e;

  localparam int unsigned DW = $clog2(2 * N);
  localparam int unsigned MW = 2 * N - 1;
  localparam logic [DW-1:0] DrainLast = DW'(2 * N - 1);

  state_e          r_state;
  logic [KW-1:0]   r_k_len;
  logic [KW-1:0]   r_beats;
  logic [DW-1:0]   r_drain;
  logic            r_first;
  logic            r_in_ready;
  logic            r_busy;
  logic            r_done;
  logic [MW-1:0]   r_mark;

  logic            w_feed;
  logic            w_take;
  logic            w_last;
  logic            w_slot0;
  logic [8*N-1:0]  w_a_lane;
  logic [8*N-1:0]  w_b_lane;

  assign w_feed  = (r_state == StFeed);
  assign w_take  = w_feed && i_in_valid;
  // Compare against k_len-1 so a full-scale k_len never needs a wrapping counter.
  assign w_last  = w_take && (r_beats == (r_k_len - KW'(1)));
  assign w_slot0 = w_feed && r_first;
  assign w_a_lane = w_take ? i_in_a : '0;
  assign w_b_lane = w_take ? i_in_b : '0;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_k_len    <= '0;
      r_beats    <= '0;
      r_drain    <= '0;
      r_first    <= 1'b0;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (i_start && (i_k_len != '0)) begin
            r_state    <= StFeed;
            r_k_len    <= i_k_len;
            r_beats    <= '0;
            r_first    <= 1'b1;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        StFeed: begin
          r_first <= 1'b0;
          if (w_take) r_beats <= r_beats + KW'(1);
          if (w_last) begin
            r_state    <= StDrain;
            r_in_ready <= 1'b0;
            r_drain    <= '0;
          end
        end
        StDrain: begin
          if (r_drain == DrainLast) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_drain <= r_drain + DW'(1);
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Slot-0 marker: r_mark[d] is high in the cycle after edge d of the tile.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mark <= '0;
    end else begin
      r_mark[0] <= w_slot0;
      for (int d = 1; d < MW; d++) r_mark[d] <= r_mark[d-1];
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_clr_row
    for (genvar k = 0; k < N; k++) begin : g_clr_col
      assign o_clear_pe[i*N+k] = r_mark[i+k];
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [7:0] r_a_out;
    logic [7:0] r_b_out;
    if (i == 0) begin : g_direct
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          r_a_out <= '0;
          r_b_out <= '0;
        end else begin
          r_a_out <= w_a_lane[7:0];
          r_b_out <= w_b_lane[7:0];
        end
      end
    end else begin : g_skew
      logic [7:0] r_a_sr [i];
      logic [7:0] r_b_sr [i];
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          for (int j = 0; j < i; j++) begin
            r_a_sr[j] <= '0;
            r_b_sr[j] <= '0;
          end
          r_a_out <= '0;
          r_b_out <= '0;
        end else begin
          r_a_sr[0] <= w_a_lane[8*i +: 8];
          r_b_sr[0] <= w_b_lane[8*i +: 8];
          for (int j = 1; j < i; j++) begin
            r_a_sr[j] <= r_a_sr[j-1];
            r_b_sr[j] <= r_b_sr[j-1];
          end
          r_a_out <= r_a_sr[i-1];
          r_b_out <= r_b_sr[i-1];
        end
      end
    end
    assign o_a_edge[8*i +: 8] = r_a_out;
    assign o_b_edge[8*i +: 8] = r_b_out;
  end

  assign o_in_ready = r_in_ready;
  assign o_busy     = r_busy;
  assign o_done     = r_done;

endmodule
